trigger_capture: RTL
====================

Name: trigger_capture

Overview:
- Receiving end of the trigger output stream: consumes sample data plus the SEW-bit event code.
- Keeps a circular pre-trigger history and captures a programmed number of post-trigger samples.
- Then replays the capture window oldest-first on an output stream with tlast.
- Configured over the same write-only system bus as the trigger block.

Parameters:
BAW, 6, bus address width
BDW, 32, bus data width
SDW, 32, sample data width
SEW, 2, sample event width (fixed encoding below, SEW>=2)
MAW, 10, capture memory address width (depth 2**MAW samples)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
bus_wready  out  1  always 1
bus_wvalid  in  1  bus write valid
bus_waddr  in  BAW  bus write address
bus_wdata  in  BDW  bus write data
bus_wselct  in  4  byte/select strobes; only bit0 used
sti_tready  out  1  input stream ready
sti_tvalid  in  1  input stream valid
sti_tevent  in  SEW  event code
sti_tdata  in  SDW  sample
sto_tready  in  1  output stream ready
sto_tvalid  out  1  output stream valid
sto_tlast  out  1  last sample of capture
sto_tdata  out  SDW  replayed sample
sts_state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 READ
sts_done  out  1  one-cycle pulse after final output transfer

Behaviour:
- Reset (rst=0, async): state IDLE, all counters 0, cfg regs 0, sto_tvalid=0, sto_tlast=0, sto_tdata=0, sts_done=0. Memory contents undefined.
- Bus writes occur on bus_wvalid & bus_wselct[0]; bus_waddr[1:0] selects the register:
  - 0 ctrl: bit0 arm, bit1 abort, bit2 ext_arm_en. Bits 0/1 are self-clearing pulses; bit2 is stored.
  - 1 cfg_pre[MAW-1:0]
  - 2 cfg_post[MAW:0]
- cfg_pre/cfg_post are copied to shadow registers on entry to ARMED; writes during capture affect the next arm only.
- Event codes on sti_tevent[1:0]: 00 none, 01 start, 10 trigger, 11 abort. Bits above 1 are ignored.
- sti_tready = 1 in IDLE/ARMED/POST (IDLE discards samples); 0 in READ.
- IDLE -> ARMED: on ctrl.arm, or on a start event transfer when ext_arm_en=1. Entry clears wr_ptr-relative fill count pre_fill to 0.
- ARMED: each transfer writes tdata to mem[wr_ptr] and increments wr_ptr (wraps mod 2**MAW). pre_fill increments, saturating at shadow_pre.
- ARMED, trigger event:
  - The trigger sample is stored; trig_adr = its address.
  - eff_pre = min(pre_fill, 2**MAW - eff_post), where eff_post = max(shadow_post,1).
  - post_cnt = eff_post-1. Next state: POST, or directly to READ if post_cnt=0.
  - A trigger before pre_fill reaches shadow_pre is legal: eff_pre is simply smaller.
- POST: each transfer stores and decrements post_cnt; the transfer that makes it 0 moves to READ. Events are ignored in POST except abort.
- Abort handling:
  - Abort event in ARMED/POST -> IDLE; the sample is not stored.
  - ctrl.abort -> IDLE from any state, including READ; sto_tvalid drops next cycle.
  - If bus abort and a stream event occur in the same cycle, bus abort wins.
  - Start events in ARMED/POST/READ are ignored.
- READ:
  - rd_ptr = trig_adr - eff_pre (mod 2**MAW); remaining = eff_pre + eff_post.
  - Synchronous memory read with one register stage to sto_tdata; skid-free: next read issued only when the output register is empty or being transferred.
  - sto_tvalid/sto_tdata are held stable while sto_tready=0.
  - sto_tlast = 1 only with the final sample.
  - After the transfer of the tlast sample: sts_done=1 for one cycle, state IDLE.
- Latency: first sto_tvalid 2 cycles after entering READ.
- Full boundary: eff_pre + eff_post never exceeds 2**MAW. When cfg_pre + cfg_post > 2**MAW, eff_pre is reduced, never eff_post.
- cfg_post=0 behaves as 1 (trigger sample only).

Test Plan:
- cfg_pre=4, cfg_post=3, arm, stream ramp 0..19 with trigger on sample 10 -> output 6,7,8,9,10,11,12; tlast on 12; sts_done pulse; state IDLE.
- cfg_pre=8, cfg_post=2, trigger on 3rd sample after arm (data 100,101,102) -> output 100,101,102,103 (eff_pre=2).
- MAW=4, cfg_pre=15, cfg_post=10, 40 samples before trigger -> exactly 16 samples out: 6 pre, trigger, then 9 post; wrap handled.
- Random sto_tready (50%) during READ -> no sample lost or duplicated; data stable while stalled; sti_tready=0 throughout READ.
- Abort event in POST, then bus ctrl.abort mid-READ, then ext_arm_en=1 with start event -> IDLE each time, no tlast emitted, re-arm succeeds from start event.
- rst low during POST -> all outputs 0 immediately; after release, state IDLE and cfg regs 0.

Source files
------------

// File: rtl/trigger_capture.sv
// Capture buffer for the trigger stream: circular pre-trigger history, post-trigger fill, then oldest-first replay with tlast.
// Latency: first replayed sample is valid 2 cycles after entering READ (RAM read register, then output register).
// Backpressure: sti_tready is low only in READ; replay stalls on sto_tready=0 with sto_tvalid/sto_tdata held stable.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   bus_w*              write-only config bus: addr 0 ctrl {ext_arm_en, abort, arm}, 1 cfg_pre, 2 cfg_post
//   sti_t*              input sample stream with event code (00 none, 01 start, 10 trigger, 11 abort)
//   sto_t*              replayed capture window, tlast on the final sample
//   sts_state/sts_done  FSM state (0 IDLE, 1 ARMED, 2 POST, 3 READ), one-cycle done pulse after the final transfer
module trigger_capture #(
    parameter int BAW = 6,
    parameter int BDW = 32,
    parameter int SDW = 32,
    parameter int SEW = 2,
    parameter int MAW = 10
) (
    input  logic           clk,
    input  logic           rst,
    output logic           bus_wready,
    input  logic           bus_wvalid,
    input  logic [BAW-1:0] bus_waddr,
    input  logic [BDW-1:0] bus_wdata,
    input  logic [3:0]     bus_wselct,
    output logic           sti_tready,
    input  logic           sti_tvalid,
    input  logic [SEW-1:0] sti_tevent,
    input  logic [SDW-1:0] sti_tdata,
    input  logic           sto_tready,
    output logic           sto_tvalid,
    output logic           sto_tlast,
    output logic [SDW-1:0] sto_tdata,
    output logic [1:0]     sts_state,
    output logic           sts_done
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_READ = 2'd3} state_t;

    localparam logic [MAW:0]   DEPTH_W = {1'b1, {MAW{1'b0}}};
    localparam logic [MAW:0]   ONE_W   = {{MAW{1'b0}}, 1'b1};
    localparam logic [MAW-1:0] ONE_A   = {{(MAW-1){1'b0}}, 1'b1};

    state_t         state_q, state_d;
    logic [MAW-1:0] cfg_pre_q, shadow_pre_q, shadow_pre_d;
    logic [MAW:0]   cfg_post_q, shadow_post_q, shadow_post_d;
    logic           ext_arm_en_q;
    logic [MAW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, pre_fill_q, pre_fill_d;
    logic [MAW:0]   post_cnt_q, post_cnt_d, remaining_q, remaining_d;
    logic           done_q, done_d;
    logic           rd_vld_q, rd_last_q, sto_tvalid_q, sto_tlast_q;
    logic [SDW-1:0] rd_dat_q, sto_tdata_q;
    logic [SDW-1:0] mem_q [2**MAW];

    logic           bus_we, ctrl_we, bus_arm, bus_abort;
    logic           sti_fire, ev_start, ev_trig, ev_abort;
    logic           mem_we, rd_issue, out_free, out_fire;
    logic [MAW:0]   eff_post_cfg, room;
    logic [MAW-1:0] eff_pre;
    logic           unused_bits;

    assign unused_bits = ^{bus_waddr, bus_wdata, bus_wselct, sti_tevent};

    assign bus_wready = 1'b1;
    assign bus_we     = bus_wvalid & bus_wselct[0];
    assign ctrl_we    = bus_we && (bus_waddr[1:0] == 2'd0);
    assign bus_arm    = ctrl_we & bus_wdata[0];
    assign bus_abort  = ctrl_we & bus_wdata[1];

    assign sti_tready = (state_q != S_READ);
    assign sti_fire   = sti_tvalid & sti_tready;
    assign ev_start   = (sti_tevent[1:0] == 2'b01);
    assign ev_trig    = (sti_tevent[1:0] == 2'b10);
    assign ev_abort   = (sti_tevent[1:0] == 2'b11);

    assign out_free = !sto_tvalid_q || sto_tready;
    assign out_fire = sto_tvalid_q && sto_tready;

    // cfg_post of 0 means "trigger sample only"; a post length beyond the
    // memory depth is clamped so the post window alone never self-overwrites.
    always_comb begin
        if (cfg_post_q == '0)           eff_post_cfg = ONE_W;
        else if (cfg_post_q > DEPTH_W)  eff_post_cfg = DEPTH_W;
        else                            eff_post_cfg = cfg_post_q;
    end

    // Pre-history is trimmed so pre + post always fits the memory.
    assign room    = DEPTH_W - shadow_post_q;
    assign eff_pre = ({1'b0, pre_fill_q} < room) ? pre_fill_q : room[MAW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_pre_q    <= '0;
            cfg_post_q   <= '0;
            ext_arm_en_q <= 1'b0;
        end else begin
            if (ctrl_we)
                ext_arm_en_q <= bus_wdata[2];
            if (bus_we && bus_waddr[1:0] == 2'd1)
                cfg_pre_q <= bus_wdata[MAW-1:0];
            if (bus_we && bus_waddr[1:0] == 2'd2)
                cfg_post_q <= bus_wdata[MAW:0];
        end
    end

    always_comb begin
        state_d       = state_q;
        shadow_pre_d  = shadow_pre_q;
        shadow_post_d = shadow_post_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        pre_fill_d    = pre_fill_q;
        post_cnt_d    = post_cnt_q;
        remaining_d   = remaining_q;
        done_d        = 1'b0;
        mem_we        = 1'b0;
        rd_issue      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus_arm || (sti_fire && ev_start && ext_arm_en_q)) begin
                    state_d       = S_ARMED;
                    pre_fill_d    = '0;
                    shadow_pre_d  = cfg_pre_q;
                    shadow_post_d = eff_post_cfg;
                end
            end
            S_ARMED: begin
                if (sti_fire) begin
                    if (ev_abort) begin
                        state_d = S_IDLE;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_A;
                        if (ev_trig) begin
                            // wr_ptr_q is the trigger sample's address
                            rd_ptr_d    = wr_ptr_q - eff_pre;
                            remaining_d = {1'b0, eff_pre} + shadow_post_q;
                            post_cnt_d  = shadow_post_q - ONE_W;
                            state_d     = (shadow_post_q == ONE_W) ? S_READ : S_POST;
                        end else if (pre_fill_q < shadow_pre_q) begin
                            pre_fill_d = pre_fill_q + ONE_A;
                        end
                    end
                end
            end
            S_POST: begin
                if (sti_fire) begin
                    if (ev_abort) begin
                        state_d = S_IDLE;
                    end else begin
                        mem_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_q + ONE_A;
                        post_cnt_d = post_cnt_q - ONE_W;
                        if (post_cnt_q == ONE_W)
                            state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                // Issue only when the output register can accept the word
                // currently in the RAM read register, so nothing needs a skid slot.
                rd_issue = (remaining_q != '0) && out_free;
                if (rd_issue) begin
                    rd_ptr_d    = rd_ptr_q + ONE_A;
                    remaining_d = remaining_q - ONE_W;
                end
                if (out_fire && sto_tlast_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (bus_abort) begin
            state_d     = S_IDLE;
            mem_we      = 1'b0;
            rd_issue    = 1'b0;
            remaining_d = '0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            shadow_pre_q  <= '0;
            shadow_post_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            pre_fill_q    <= '0;
            post_cnt_q    <= '0;
            remaining_q   <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_pre_q  <= shadow_pre_d;
            shadow_post_q <= shadow_post_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            pre_fill_q    <= pre_fill_d;
            post_cnt_q    <= post_cnt_d;
            remaining_q   <= remaining_d;
            done_q        <= done_d;
        end
    end

    // Capture memory: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[wr_ptr_q] <= sti_tdata;
        if (rd_issue)
            rd_dat_q <= mem_q[rd_ptr_q];
    end

    // Two-stage replay pipeline: RAM read register -> output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_vld_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            sto_tvalid_q <= 1'b0;
            sto_tlast_q  <= 1'b0;
            sto_tdata_q  <= '0;
        end else if (bus_abort) begin
            rd_vld_q     <= 1'b0;
            sto_tvalid_q <= 1'b0;
            sto_tlast_q  <= 1'b0;
        end else begin
            if (out_free) begin
                sto_tvalid_q <= rd_vld_q;
                sto_tlast_q  <= rd_vld_q & rd_last_q;
                if (rd_vld_q)
                    sto_tdata_q <= rd_dat_q;
            end
            if (rd_issue) begin
                rd_vld_q  <= 1'b1;
                rd_last_q <= (remaining_q == ONE_W);
            end else if (out_free) begin
                rd_vld_q <= 1'b0;
            end
        end
    end

    assign sto_tvalid = sto_tvalid_q;
    assign sto_tlast  = sto_tlast_q;
    assign sto_tdata  = sto_tdata_q;
    assign sts_state  = state_q;
    assign sts_done   = done_q;

endmodule
